// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_ILLEGAL = 2'b01;
  localparam logic [1:0] HALT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB,
    ST_MEM_WRITE, ST_EXECUTE, ST_R_WB, ST_ADDI_EXEC, ST_ADDI_WB,
    ST_BRANCH, ST_JUMP, ST_HALT
  } mc_state_t;

  // Datapath control word decoded from the current state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } mc_ctl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state watchdog: clear/increment/saturate counter with an
// expired flag at LIMIT. LIMIT of 0 disables expiry.
module mem_wait_timer #(
  parameter int LIMIT = 16,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] cnt;

  // Count stalled wait cycles; hold at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + W'(1);
  end

  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback,
// stalls on mem_ready, halts on illegal opcode or memory timeout.
module mc_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter int TO_CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic [1:0] halt_cause
);

  mc_state_t  state, state_nxt;
  logic [1:0] cause_q, cause_nxt;
  logic       wait_st, expired;
  mc_ctl_t    ctl;

  assign wait_st = (state == ST_FETCH) || (state == ST_MEM_READ) ||
                   (state == ST_MEM_WRITE);

  // Counter restarts on every state change, so each wait state starts fresh.
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT), .W(TO_CNT_WIDTH)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_nxt != state),
    .inc     (wait_st && !mem_ready),
    .expired (expired)
  );

  // Next-state selection; a same-cycle mem_ready beats the watchdog.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    if (wait_st && !mem_ready && expired) begin
      state_nxt = ST_HALT;
      cause_nxt = HALT_TIMEOUT;
    end else begin
      case (state)
        ST_IDLE:      if (start) state_nxt = ST_FETCH;
        ST_FETCH:     if (mem_ready) state_nxt = ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_RTYPE:     state_nxt = ST_EXECUTE;
            OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
            OP_ADDI:      state_nxt = ST_ADDI_EXEC;
            OP_BEQ:       state_nxt = ST_BRANCH;
            OP_J:         state_nxt = ST_JUMP;
            default: begin
              state_nxt = ST_HALT;
              cause_nxt = HALT_ILLEGAL;
            end
          endcase
        end
        ST_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
        ST_MEM_READ:  if (mem_ready) state_nxt = ST_MEM_WB;
        ST_MEM_WRITE: if (mem_ready) state_nxt = ST_FETCH;
        ST_EXECUTE:   state_nxt = ST_R_WB;
        ST_ADDI_EXEC: state_nxt = ST_ADDI_WB;
        ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP:
                      state_nxt = ST_FETCH;
        ST_HALT:      state_nxt = ST_HALT;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and latched halt cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cause_q <= HALT_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  // Control word decode; only FETCH and MEM_WRITE look at mem_ready.
  always_comb begin
    ctl = '0;
    case (state)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCS_ALU;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      ST_DECODE:    ctl.alu_src_b = SRCB_IMM_SH;
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = mem_ready;
      end
      ST_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REG;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCS_ALUOUT;
        ctl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PCS_JUMP;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign pc_source     = ctl.pc_source;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_dst       = ctl.reg_dst;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign instr_done    = ctl.instr_done;
  assign halted        = (state == ST_HALT);
  assign halt_cause    = cause_q;

endmodule
